duty_playback: RTL and testbench

//  Playback reader for the recorded duty-cycle memory. It walks stored (X,Y) duty pairs in order

---
 rtl/duty_playback.sv | 183 ++++++++++++++++++
 tb/tb_duty_playback.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_playback.sv
// Playback reader for the recorded duty-cycle memory.
// It walks the stored (X,Y) pairs in order and holds each pair on DC_X/DC_Y
// for Step_Div+3 cycles. Playback is either one-shot or looped.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no replay; outputs zero; waiting for Play_Sw with Rec_Len!=0
// FETCH | read strobe issued for entry addr
// LOAD  | memory data valid; pair latched onto DC_X/DC_Y
// HOLD  | pair held while tick counts down to zero
// DONE  | one-shot pass finished; last pair held until Play_Sw drops
module duty_playback #(
  parameter int DUTY_W = 6,
  parameter int ADDR_W = 8,
  parameter int TICK_W = 12
) (
  input  logic              sysclk,
  input  logic              Reset_Sw,
  input  logic              Play_Sw,
  input  logic              Loop_Sw,
  input  logic [ADDR_W:0]   Rec_Len,
  input  logic [TICK_W-1:0] Step_Div,
  output logic              Rd_En,
  output logic [ADDR_W-1:0] Rd_Addr,
  input  logic [DUTY_W-1:0] Rd_X,
  input  logic [DUTY_W-1:0] Rd_Y,
  output logic [DUTY_W-1:0] DC_X,
  output logic [DUTY_W-1:0] DC_Y,
  output logic              Playing,
  output logic              Step_Strobe,
  output logic              Done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DUTY_W-1:0]   dc_x_q, dc_x_d;
  logic [DUTY_W-1:0]   dc_y_q, dc_y_d;
  logic                strobe_q, strobe_d;
  logic                done_q, done_d;

  // len_q-1 kept one bit wider than addr so a full-depth record compares cleanly
  logic [ADDR_W:0]     len_m1;
  logic                last_entry;

  assign len_m1     = len_q - (ADDR_W+1)'(1);
  assign last_entry = ({1'b0, addr_q} == len_m1);

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge sysclk or posedge Reset_Sw) begin
    if (Reset_Sw) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      tick_q   <= '0;
      len_q    <= '0;
      dc_x_q   <= '0;
      dc_y_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tick_q   <= tick_d;
      len_q    <= len_d;
      dc_x_q   <= dc_x_d;
      dc_y_q   <= dc_y_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-datapath logic; abort on Play_Sw=0 outranks every HOLD decision
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tick_d   = tick_q;
    len_d    = len_q;
    dc_x_d   = dc_x_q;
    dc_y_d   = dc_y_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        dc_x_d = '0;
        dc_y_d = '0;
        addr_d = '0;
        if (Play_Sw && (Rec_Len != '0)) begin
          len_d   = Rec_Len;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (!Play_Sw) begin
          state_d = S_IDLE;
          addr_d  = '0;
          dc_x_d  = '0;
          dc_y_d  = '0;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!Play_Sw) begin
          state_d = S_IDLE;
          addr_d  = '0;
          dc_x_d  = '0;
          dc_y_d  = '0;
        end else begin
          dc_x_d   = Rd_X;
          dc_y_d   = Rd_Y;
          strobe_d = 1'b1;
          tick_d   = Step_Div;
          state_d  = S_HOLD;
        end
      end

      S_HOLD: begin
        if (!Play_Sw) begin
          state_d = S_IDLE;
          addr_d  = '0;
          dc_x_d  = '0;
          dc_y_d  = '0;
        end else if (tick_q != '0) begin
          tick_d = tick_q - TICK_W'(1);
        end else if (!last_entry) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else if (Loop_Sw) begin
          // record length is only re-read at a wrap, so a shrinking record takes effect here
          addr_d = '0;
          len_d  = Rec_Len;
          if (Rec_Len == '0) begin
            state_d = S_IDLE;
            dc_x_d  = '0;
            dc_y_d  = '0;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (!Play_Sw) begin
          state_d = S_IDLE;
          addr_d  = '0;
          dc_x_d  = '0;
          dc_y_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        dc_x_d  = '0;
        dc_y_d  = '0;
      end
    endcase
  end

  assign Rd_En       = (state_q == S_FETCH);
  assign Rd_Addr     = (state_q == S_IDLE) ? '0 : addr_q;
  assign Playing     = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_HOLD);
  assign DC_X        = dc_x_q;
  assign DC_Y        = dc_y_q;
  assign Step_Strobe = strobe_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_duty_playback.sv
// Self-checking bench for duty_playback: a timeline model derives every
// output from the cycle count since playback started, plus directed literal checks.
module tb_duty_playback;

  logic       sysclk;
  logic       Reset_Sw;
  logic       Play_Sw;
  logic       Loop_Sw;
  logic [8:0] Rec_Len;
  logic [11:0] Step_Div;
  logic       Rd_En;
  logic [7:0] Rd_Addr;
  logic [5:0] Rd_X;
  logic [5:0] Rd_Y;
  logic [5:0] DC_X;
  logic [5:0] DC_Y;
  logic       Playing;
  logic       Step_Strobe;
  logic       Done;

  int total = 0;
  int bad   = 0;

  logic [5:0] mem_x [256];
  logic [5:0] mem_y [256];

  int strobe_cnt = 0;
  int done_cnt   = 0;
  int rden_cnt   = 0;

  // model: 0 idle, 1 playing, 2 done
  int m_mode = 0;
  int m_t    = 0;
  int m_p    = 3;
  int m_l    = 1;
  bit m_done_first = 1'b0;

  duty_playback #(.DUTY_W(6), .ADDR_W(8), .TICK_W(12)) dut (
    .sysclk      (sysclk),
    .Reset_Sw    (Reset_Sw),
    .Play_Sw     (Play_Sw),
    .Loop_Sw     (Loop_Sw),
    .Rec_Len     (Rec_Len),
    .Step_Div    (Step_Div),
    .Rd_En       (Rd_En),
    .Rd_Addr     (Rd_Addr),
    .Rd_X        (Rd_X),
    .Rd_Y        (Rd_Y),
    .DC_X        (DC_X),
    .DC_Y        (DC_Y),
    .Playing     (Playing),
    .Step_Strobe (Step_Strobe),
    .Done        (Done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // synchronous-read memory
  always @(posedge sysclk) begin
    if (Rd_En) begin
      Rd_X <= mem_x[Rd_Addr];
      Rd_Y <= mem_y[Rd_Addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #2;
    end
  endtask

  // timeline model: count cycles since the start edge; everything else is arithmetic on that
  always @(posedge sysclk or posedge Reset_Sw) begin
    if (Reset_Sw) begin
      m_mode = 0;
      m_done_first = 1'b0;
    end else begin
      m_done_first = 1'b0;
      case (m_mode)
        0: if (Play_Sw && Rec_Len != 0) begin
             m_mode = 1;
             m_t = 1;
             m_p = int'(Step_Div) + 3;
             m_l = int'(Rec_Len);
           end
        1: if (!Play_Sw) m_mode = 0;
           else begin
             m_t++;
             if (!Loop_Sw && (m_t - 1 == m_l * m_p)) begin
               m_mode = 2;
               m_done_first = 1'b1;
             end
           end
        2: if (!Play_Sw) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  // compare process: every cycle, on the falling edge
  always @(negedge sysclk) begin
    int pos, k, ph, e;
    int x_en, x_addr, x_dx, x_dy, x_play, x_stb, x_done;
    bit chk_addr;
    x_en = 0; x_addr = 0; x_dx = 0; x_dy = 0; x_play = 0; x_stb = 0; x_done = 0;
    chk_addr = 1'b1;
    if (Reset_Sw || m_mode == 0) begin
      chk_addr = 1'b1;
    end else if (m_mode == 1) begin
      pos = m_t - 1;
      k = pos / m_p;
      ph = pos % m_p;
      x_play = 1;
      x_en = (ph == 0) ? 1 : 0;
      chk_addr = (ph == 0);
      x_addr = k % m_l;
      x_stb = (ph == 2) ? 1 : 0;
      e = (ph >= 2) ? k : k - 1;
      if (e >= 0) begin
        x_dx = int'(mem_x[e % m_l]);
        x_dy = int'(mem_y[e % m_l]);
      end
    end else begin
      chk_addr = 1'b0;
      x_dx = int'(mem_x[m_l - 1]);
      x_dy = int'(mem_y[m_l - 1]);
      x_done = m_done_first ? 1 : 0;
    end
    chk("rd_en", int'(Rd_En), x_en);
    if (chk_addr) chk("rd_addr", int'(Rd_Addr), x_addr);
    chk("dc_x", int'(DC_X), x_dx);
    chk("dc_y", int'(DC_Y), x_dy);
    chk("playing", int'(Playing), x_play);
    chk("step_strobe", int'(Step_Strobe), x_stb);
    chk("done", int'(Done), x_done);
    if (Step_Strobe) strobe_cnt++;
    if (Done) done_cnt++;
    if (Rd_En) rden_cnt++;
  end

  int s_stb, s_done, s_rd;

  initial begin
    Reset_Sw = 1'b1;
    Play_Sw  = 1'b0;
    Loop_Sw  = 1'b0;
    Rec_Len  = 9'd3;
    Step_Div = 12'd4;
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
    end
    mem_x[0] = 6'd10; mem_x[1] = 6'd20; mem_x[2] = 6'd30;
    mem_y[0] = 6'd1;  mem_y[1] = 6'd2;  mem_y[2] = 6'd3;
    step(3);
    chk("rst_dc_x", int'(DC_X), 0);
    chk("rst_playing", int'(Playing), 0);
    Reset_Sw = 1'b0;
    step(2);

    // T1: reset mid-HOLD
    Play_Sw = 1'b1;
    step(1);
    step(12);
    chk("t1_in_hold", int'(Playing), 1);
    Reset_Sw = 1'b1;
    Play_Sw = 1'b0;
    #1;
    chk("t1_dc_x", int'(DC_X), 0);
    chk("t1_dc_y", int'(DC_Y), 0);
    chk("t1_rd_en", int'(Rd_En), 0);
    chk("t1_playing", int'(Playing), 0);
    step(2);
    Reset_Sw = 1'b0;
    s_stb = strobe_cnt; s_done = done_cnt;
    step(10);
    chk("t1_no_strobe", strobe_cnt - s_stb, 0);
    chk("t1_no_done", done_cnt - s_done, 0);

    // T2: one-shot
    s_stb = strobe_cnt; s_done = done_cnt;
    Play_Sw = 1'b1;
    step(1);
    chk("t2_rd_en0", int'(Rd_En), 1);
    chk("t2_addr0", int'(Rd_Addr), 0);
    step(3);
    chk("t2_x0", int'(DC_X), 10);
    chk("t2_y0", int'(DC_Y), 1);
    step(7);
    chk("t2_x1", int'(DC_X), 20);
    step(4);
    chk("t2_addr2", int'(Rd_Addr), 2);
    step(3);
    chk("t2_x2", int'(DC_X), 30);
    chk("t2_y2", int'(DC_Y), 3);
    step(8);
    chk("t2_end_playing", int'(Playing), 0);
    chk("t2_end_x", int'(DC_X), 30);
    chk("t2_strobes", strobe_cnt - s_stb, 3);
    chk("t2_done_once", done_cnt - s_done, 1);
    step(10);
    chk("t2_hold_x", int'(DC_X), 30);
    chk("t2_done_still_once", done_cnt - s_done, 1);
    Play_Sw = 1'b0;
    step(2);
    chk("t2_idle_x", int'(DC_X), 0);

    // T3: loop
    Loop_Sw = 1'b1;
    s_stb = strobe_cnt; s_done = done_cnt;
    Play_Sw = 1'b1;
    step(1);
    step(21);
    chk("t3_wrap_en", int'(Rd_En), 1);
    chk("t3_wrap_addr", int'(Rd_Addr), 0);
    step(2);
    chk("t3_wrap_x", int'(DC_X), 10);
    step(1);
    chk("t3_strobes4", strobe_cnt - s_stb, 4);
    step(20);
    chk("t3_strobes6", strobe_cnt - s_stb, 6);
    chk("t3_no_done", done_cnt - s_done, 0);
    Play_Sw = 1'b0;
    step(2);
    Loop_Sw = 1'b0;

    // T4: empty record
    Rec_Len = 9'd0;
    s_rd = rden_cnt;
    Play_Sw = 1'b1;
    step(100);
    chk("t4_no_reads", rden_cnt - s_rd, 0);
    chk("t4_dc_x", int'(DC_X), 0);
    chk("t4_playing", int'(Playing), 0);
    Play_Sw = 1'b0;
    Rec_Len = 9'd3;
    step(2);

    // T5: abort in the third HOLD cycle of entry 1
    s_done = done_cnt;
    Play_Sw = 1'b1;
    step(1);
    step(11);
    chk("t5_pre_x", int'(DC_X), 20);
    Play_Sw = 1'b0;
    step(1);
    chk("t5_abort_x", int'(DC_X), 0);
    chk("t5_abort_y", int'(DC_Y), 0);
    chk("t5_abort_playing", int'(Playing), 0);
    Play_Sw = 1'b1;
    step(1);
    chk("t5_restart_en", int'(Rd_En), 1);
    chk("t5_restart_addr", int'(Rd_Addr), 0);
    step(10);
    Play_Sw = 1'b0;
    step(2);
    chk("t5_no_done", done_cnt - s_done, 0);

    // T6: full depth, no hold
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = 6'(i);
      mem_y[i] = 6'(63 - (i % 64));
    end
    Rec_Len = 9'd256;
    Step_Div = 12'd0;
    Loop_Sw = 1'b1;
    Play_Sw = 1'b1;
    step(1);
    step(765);
    chk("t6_en255", int'(Rd_En), 1);
    chk("t6_addr255", int'(Rd_Addr), 255);
    step(2);
    chk("t6_x255", int'(DC_X), 63);
    step(1);
    chk("t6_en_wrap", int'(Rd_En), 1);
    chk("t6_addr_wrap", int'(Rd_Addr), 0);
    step(2);
    chk("t6_x_wrap", int'(DC_X), 0);
    step(30);
    Play_Sw = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
